// File: rtl/hpdcache_downsize_arb.sv
// Packet-locked arbiter, tag FIFO and narrow-read sequencer in front of a shared refill downsize buffer.
// Define HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN for fixed-priority (lowest index) grant instead of round-robin.
module hpdcache_downsize_arb #(
    parameter  int N_REQ    = 2,
    parameter  int WR_WIDTH = 256,
    parameter  int RD_WIDTH = 64,
    parameter  int DEPTH    = 2,
    localparam int RD_WORDS = WR_WIDTH / RD_WIDTH,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*WR_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]          req_last_i,
    output logic                      buf_w_o,
    input  logic                      buf_wok_i,
    output logic [WR_WIDTH-1:0]       buf_wdata_o,
    output logic                      buf_r_o,
    input  logic                      buf_rok_i,
    input  logic [RD_WIDTH-1:0]       buf_rdata_i,
    output logic                      cons_valid_o,
    input  logic                      cons_ready_i,
    output logic [RD_WIDTH-1:0]       cons_data_o,
    output logic [ID_W-1:0]           cons_id_o,
    output logic                      cons_last_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WC_W  = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   w_rr_base;
    logic [N_REQ-1:0]  w_vld_rot;
    logic [ID_W:0]     w_sum;
    logic              w_idle_vld;
    logic [ID_W-1:0]   w_gnt;
    logic              w_gnt_vld;
    logic              w_gvalid;
    logic              w_glast;
    logic [WR_WIDTH-1:0] w_wdata;
    logic              w_can_w;
    logic              w_push;
    logic              w_pop;

    logic [ID_W:0]     r_tag_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_tag_cnt;
    logic              w_tag_full;
    logic              w_tag_empty;
    logic [WC_W-1:0]   r_wcnt;
    logic              w_wlast;

`ifdef HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN
    assign w_rr_base = '0;
`else
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_nxt;
    assign w_rr_base = r_rr_ptr;
    assign w_rr_nxt  = (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
`endif

    // Rotate so bit 0 is the producer at the priority pointer; first set bit wins.
    assign w_vld_rot = N_REQ'({req_valid_i, req_valid_i} >> w_rr_base);

    always_comb begin
        w_idle_vld = 1'b0;
        w_sum      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_vld_rot[i]) begin
                w_idle_vld = 1'b1;
                w_sum      = {1'b0, w_rr_base} + (ID_W + 1)'(i);
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (r_state == LOCKED) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_owner;
        end else if (w_idle_vld) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ID_W'((w_sum >= (ID_W + 1)'(N_REQ)) ? w_sum - (ID_W + 1)'(N_REQ) : w_sum);
        end
    end

    always_comb begin
        w_gvalid = 1'b0;
        w_glast  = 1'b0;
        w_wdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == ID_W'(i)) begin
                w_gvalid = req_valid_i[i];
                w_glast  = req_last_i[i];
                w_wdata  = req_data_i[i*WR_WIDTH +: WR_WIDTH];
            end
        end
    end

    assign w_can_w = buf_wok_i & ~w_tag_full;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = ~rst_i & w_can_w & w_gnt_vld & (w_gnt == ID_W'(i));
        end
    end

    assign w_push      = ~rst_i & w_can_w & w_gnt_vld & w_gvalid;
    assign buf_w_o     = w_push;
    assign buf_wdata_o = w_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_owner  <= '0;
`ifndef HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`endif
        end else if (w_push) begin
            if (w_glast) begin
                r_state  <= IDLE;
`ifndef HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN
                r_rr_ptr <= w_rr_nxt;
`endif
            end else begin
                r_state <= LOCKED;
                r_owner <= w_gnt;
            end
        end
    end

    // Full is judged on registered occupancy only, mirroring the buffer's own full flag.
    assign w_tag_full  = (r_tag_cnt == CNT_W'(DEPTH));
    assign w_tag_empty = (r_tag_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (w_push) r_tag_mem[r_wptr] <= {w_gnt, w_glast};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    assign cons_valid_o = ~rst_i & buf_rok_i & ~w_tag_empty;
    assign buf_r_o      = cons_valid_o & cons_ready_i;
    assign w_wlast      = (r_wcnt == WC_W'(RD_WORDS - 1));
    assign w_pop        = buf_r_o & w_wlast;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        r_wcnt <= '0;
        else if (buf_r_o) r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
    end

    assign cons_data_o = buf_rdata_i;
    assign cons_id_o   = r_tag_mem[r_rptr][ID_W:1];
    assign cons_last_o = r_tag_mem[r_rptr][0] & w_wlast;

endmodule

// File: tb/tb_hpdcache_downsize_arb.sv
// Directed bench for hpdcache_downsize_arb with a behavioural downsize buffer and a narrow-word scoreboard.
module tb_hpdcache_downsize_arb;
    localparam int N_REQ    = 2;
    localparam int WR_WIDTH = 256;
    localparam int RD_WIDTH = 64;
    localparam int DEPTH    = 2;
    localparam int RD_WORDS = WR_WIDTH / RD_WIDTH;
    localparam int ID_W     = 1;
`ifdef HPDCACHE_DOWNSIZE_ARB_FIXED_PRIO_EN
    localparam logic [7:0] RR_ORD  = 8'hF0;
    localparam logic [7:0] STR_ORD = 8'hF0;
`else
    localparam logic [7:0] RR_ORD  = 8'hAA;
    localparam logic [7:0] STR_ORD = 8'hE4;
`endif

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [N_REQ-1:0]          req_valid_i;
    logic [N_REQ-1:0]          req_ready_o;
    logic [N_REQ*WR_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]          req_last_i;
    logic                      buf_w_o;
    logic                      buf_wok_i;
    logic [WR_WIDTH-1:0]       buf_wdata_o;
    logic                      buf_r_o;
    logic                      buf_rok_i;
    logic [RD_WIDTH-1:0]       buf_rdata_i;
    logic                      cons_valid_o;
    logic                      cons_ready_i;
    logic [RD_WIDTH-1:0]       cons_data_o;
    logic [ID_W-1:0]           cons_id_o;
    logic                      cons_last_o;

    hpdcache_downsize_arb #(
        .N_REQ(N_REQ), .WR_WIDTH(WR_WIDTH), .RD_WIDTH(RD_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .req_last_i(req_last_i),
        .buf_w_o(buf_w_o), .buf_wok_i(buf_wok_i), .buf_wdata_o(buf_wdata_o),
        .buf_r_o(buf_r_o), .buf_rok_i(buf_rok_i), .buf_rdata_i(buf_rdata_i),
        .cons_valid_o(cons_valid_o), .cons_ready_i(cons_ready_i),
        .cons_data_o(cons_data_o), .cons_id_o(cons_id_o), .cons_last_o(cons_last_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [WR_WIDTH-1:0] got, input logic [WR_WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural downsize buffer: DEPTH wide entries, read out low word first.
    logic [WR_WIDTH-1:0] bmem [DEPTH];
    int bwp, brp, bcnt, bidx;
    assign buf_wok_i   = (bcnt < DEPTH);
    assign buf_rok_i   = (bcnt > 0);
    assign buf_rdata_i = bmem[brp][bidx*RD_WIDTH +: RD_WIDTH];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bwp <= 0; brp <= 0; bcnt <= 0; bidx <= 0;
        end else begin
            if (buf_w_o) begin
                bmem[bwp] <= buf_wdata_o;
                bwp <= (bwp + 1) % DEPTH;
            end
            if (buf_r_o) begin
                if (bidx == RD_WORDS - 1) begin
                    bidx <= 0;
                    brp  <= (brp + 1) % DEPTH;
                end else begin
                    bidx <= bidx + 1;
                end
            end
            bcnt <= bcnt + (buf_w_o ? 1 : 0) - ((buf_r_o && bidx == RD_WORDS - 1) ? 1 : 0);
        end
    end

    typedef struct {
        logic [RD_WIDTH-1:0] d;
        int                  id;
        bit                  last;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [WR_WIDTH-1:0] mkflit(input int p, input int n);
        logic [WR_WIDTH-1:0] f;
        for (int w = 0; w < RD_WORDS; w++)
            f[w*RD_WIDTH +: RD_WIDTH] = {16'hA5A5, 8'(p), 8'(n), 24'h0, 8'(w)};
        return f;
    endfunction

    int cur_n [N_REQ];
    logic [N_REQ-1:0] rdy_s, acc_s;
    logic wok_s;

    task automatic drive(input int p, input int n, input bit last);
        req_valid_i[p] = 1'b1;
        req_data_i[p*WR_WIDTH +: WR_WIDTH] = mkflit(p, n);
        req_last_i[p] = last;
        cur_n[p] = n;
    endtask

    // One cycle: sample at negedge, log accepted flits into the scoreboard, return after the edge.
    task automatic step();
        logic [WR_WIDTH-1:0] f;
        exp_t e;
        @(negedge clk_i);
        rdy_s = req_ready_o;
        acc_s = req_valid_i & req_ready_o;
        wok_s = buf_wok_i;
        for (int p = 0; p < N_REQ; p++) begin
            if (acc_s[p]) begin
                f = mkflit(p, cur_n[p]);
                chk("buf_w", buf_w_o, 1);
                chk("buf_wdata", buf_wdata_o, f);
                for (int w = 0; w < RD_WORDS; w++) begin
                    e.d    = f[w*RD_WIDTH +: RD_WIDTH];
                    e.id   = p;
                    e.last = req_last_i[p] && (w == RD_WORDS - 1);
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && cons_valid_o && cons_ready_i) begin
            chk("buf_r", buf_r_o, 1);
            if (exp_q.size() == 0) begin
                chk("cons_extra_word", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("cons_data", cons_data_o, e.d);
                chk("cons_id", cons_id_o, e.id);
                chk("cons_last", cons_last_o, e.last);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.delete();
        rst_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        req_valid_i = '0;
        repeat (40) step();
        chk({nm, "_drain_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_seq(input string nm, input bit p0_two, input logic [7:0] ord);
        int np [N_REQ];
        int k;
        k = 0;
        for (int p = 0; p < N_REQ; p++) np[p] = 0;
        drive(0, 0, !p0_two);
        drive(1, 0, 1'b1);
        for (int c = 0; c < 200 && k < 8; c++) begin
            step();
            chk({nm, "_tag_occ_le_depth"}, dut.r_tag_cnt <= DEPTH, 1);
            for (int p = 0; p < N_REQ; p++) begin
                if (acc_s[p] && k < 8) begin
                    chk({nm, "_grant_order"}, p, (ord >> k) & 8'h1);
                    k++;
                    np[p]++;
                    if (np[p] < 4) drive(p, np[p], (p == 0 && p0_two) ? (np[p] % 2 == 1) : 1'b1);
                    else req_valid_i[p] = 1'b0;
                end
            end
        end
        chk({nm, "_accept_count"}, k, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit done;
        rst_i = 1'b1;
        req_valid_i = '1;
        req_data_i = '0;
        req_last_i = '0;
        cons_ready_i = 1'b1;
        for (int p = 0; p < N_REQ; p++) cur_n[p] = 0;

        // Outputs held low during reset even with requests pending.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_buf_w", buf_w_o, 0);
        chk("rst_buf_r", buf_r_o, 0);
        chk("rst_cons_valid", cons_valid_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        req_valid_i = '0;
        #1;
        chk("post_rst_cons_valid", cons_valid_o, 0);
        chk("post_rst_req_ready", req_ready_o, 0);

        // Single producer, 2-flit packet.
        drive(0, 0, 1'b0);
        step();
        chk("single_a_acc", acc_s, 2'b01);
        chk("single_first_word_lat", cons_valid_o, 1);
        drive(0, 1, 1'b1);
        step();
        chk("single_b_acc", acc_s, 2'b01);
        drain("single");

        // Round-robin with continuous single-flit packets.
        do_reset();
        cons_ready_i = 1'b1;
        run_seq("rr", 1'b0, RR_ORD);
        drain("rr");

        // Lock hold.
        do_reset();
        cons_ready_i = 1'b1;
        drive(1, 0, 1'b0);
        step();
        chk("lock_f0_acc", acc_s, 2'b10);
        req_valid_i[1] = 1'b0;
        drive(0, 0, 1'b1);
        repeat (2) begin
            step();
            chk("lock_gap_rdy0", rdy_s[0], 0);
            chk("lock_gap_acc", acc_s, 0);
        end
        drive(1, 1, 1'b0);
        step();
        chk("lock_f1_acc", acc_s, 2'b10);
        drive(1, 2, 1'b1);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            chk("lock_hold_rdy0", rdy_s[0], 0);
            if (acc_s[1]) done = 1'b1;
        end
        chk("lock_f2_acc", done, 1);
        drive(1, 3, 1'b1);
        step();
        chk("lock_next_rdy0", rdy_s[0], wok_s);
        chk("lock_next_rdy1", rdy_s[1], 0);
        done = (acc_s != 0);
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            done = (acc_s != 0);
        end
        chk("lock_next_grant", acc_s, 2'b01);
        drain("lock");

        // Full boundary: two flits fill buffer and tags, third waits for the first tag pop.
        do_reset();
        cons_ready_i = 1'b0;
        drive(0, 0, 1'b1);
        step();
        chk("full_f0_acc", acc_s, 2'b01);
        drive(0, 1, 1'b1);
        step();
        chk("full_f1_acc", acc_s, 2'b01);
        drive(0, 2, 1'b1);
        repeat (2) begin
            step();
            chk("full_hold_rdy", rdy_s, 0);
        end
        cons_ready_i = 1'b1;
        for (int i = 0; i < RD_WORDS; i++) begin
            step();
            chk("full_drain_rdy", rdy_s[0], 0);
        end
        step();
        chk("full_release_acc", acc_s, 2'b01);
        drain("full");

        // Steady mixed stream with simultaneous push and pop.
        do_reset();
        cons_ready_i = 1'b1;
        run_seq("stream", 1'b1, STR_ORD);
        drain("stream");

        // Reset mid-packet discards the lock and pending tags.
        do_reset();
        cons_ready_i = 1'b1;
        drive(1, 0, 1'b0);
        step();
        chk("rstmid_f0_acc", acc_s, 2'b10);
        drive(1, 1, 1'b0);
        drive(0, 0, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstmid_req_ready", req_ready_o, 0);
        chk("rstmid_buf_w", buf_w_o, 0);
        chk("rstmid_buf_r", buf_r_o, 0);
        chk("rstmid_cons_valid", cons_valid_o, 0);
        @(posedge clk_i);
        #1;
        exp_q.delete();
        rst_i = 1'b0;
        #1;
        chk("rstmid_post_cons_valid", cons_valid_o, 0);
        step();
        chk("rstmid_next_grant", acc_s, 2'b01);
        drain("rstmid");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
